call_stack_unit: RTL and testbench
==================================

Name: call_stack_unit

Overview:
- Return-address/flags stack answering the control unit's push_stack/pop_stack strobes for callSubrutine/returnSubrutine.
- On push it stores the current PC value together with the control unit's 4-bit flags.
- On pop it presents the saved PC, for loading into the PC, and the saved flags, which the control unit latches from in_stack_flags in the same cycle.
- Sits between control unit, PC register and the flags path; it is the responder end of the CU's stack interface.

Parameters:
- DEPTH, 8, number of stack entries (>=2).
- PC_WIDTH, 8, width of a stored return address.
- FLAG_WIDTH, 4, width of stored flags; must match the control unit's flags.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_push_en  input  1  push request (CU push_stack strobe).
- in_pop_en  input  1  pop request (CU pop_stack strobe).
- in_pc  input  PC_WIDTH  return address to store on push.
- in_flags  input  FLAG_WIDTH  flags to store on push (CU out_flags).
- out_pc  output  PC_WIDTH  PC field of top entry.
- out_flags  output  FLAG_WIDTH  flags field of top entry (to CU in_stack_flags).
- out_depth  output  $clog2(DEPTH+1)  current number of valid entries.
- out_empty  output  1  depth == 0.
- out_full  output  1  depth == DEPTH.
- out_overflow  output  1  sticky: push attempted while full.
- out_underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async assert, any time, including mid-sequence):
  - sp/depth=0, out_empty=1, out_full=0, out_overflow=0, out_underflow=0.
  - out_pc=0 and out_flags=0 because the stack is empty.
  - Storage array contents are not reset.
  - Reset release is synchronous-safe: no operation takes effect on the edge during which rst is high.
- Storage: DEPTH entries of {flags, pc}; sp points to next free slot; top = entry[sp-1].
- Read path is combinational from registered storage:
  - out_pc/out_flags = top entry when depth>0, else all zeros.
  - The top must be valid in the same cycle in_pop_en is high, because the CU and PC sample it on that edge (zero-latency read, pop takes effect at the edge).
- Push only (push=1, pop=0):
  - not full: entry[sp] <= {in_flags, in_pc}, sp <= sp+1. New top is visible the cycle after the edge.
  - full: no change to storage or sp; out_overflow <= 1.
- Pop only (push=0, pop=1):
  - not empty: sp <= sp-1; outputs show the popped entry during the pop cycle and the next-lower entry afterwards.
  - empty: no change; out_underflow <= 1; outputs stay zero.
- Push and pop together:
  - not empty: replace top. entry[sp-1] <= {in_flags, in_pc}, sp unchanged. The old top is presented during the cycle, the new value after the edge. No overflow even if full.
  - empty: behaves as push only; no underflow flag.
- Sticky flags clear only on rst.
- Neither strobe: hold all state.
- Strobes are level-sampled each edge; a request held N cycles performs N operations. The CU asserts them for exactly one microstep.
- out_depth/out_empty/out_full are derived from sp registers, with no extra latency.
- Push data is captured on the edge; in_pc/in_flags need only be stable at that edge.

Test Plan:
- Reset then idle: all outputs 0, out_empty=1. Assert rst mid-run with depth 3 -> depth=0 immediately, before the next clk edge.
- Push pc=0x12/flags=0x1, then pc=0x34/flags=0x8 -> depth=2, top shows 0x34/0x8. Pop cycle still shows 0x34/0x8. After the edge, top shows 0x12/0x1, depth=1.
- Push DEPTH=8 entries pc=0x10..0x17 -> out_full=1. Ninth push pc=0xFF -> depth stays 8, top 0x17, out_overflow=1 and stays set. Pop 8 times -> values read 0x17 down to 0x10 in order, out_empty=1.
- Pop on empty -> outputs 0, depth 0, out_underflow=1. Following push 0x05/0x2 -> works normally, underflow remains 1.
- With depth=1 (top 0x20/0x4), assert push+pop with pc=0x21/flags=0x3 -> during the cycle top reads 0x20/0x4. After the edge top reads 0x21/0x3, depth=1. Repeat at full -> no overflow. Repeat at empty -> depth becomes 1, no underflow.
- CU-style sequence: push 0x40/0x1, idle 3 cycles, pop -> flags value 0x1 is on out_flags at the pop edge for the CU to latch, then out_empty=1.

Source files
------------

// File: rtl/call_stack_unit_if.sv
// Stack request/response bundle between the control unit and the call stack.
interface call_stack_unit_if #(
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 8,
  parameter int FLAG_WIDTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic                  in_push_en;
  logic                  in_pop_en;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [FLAG_WIDTH-1:0] in_flags;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [FLAG_WIDTH-1:0] out_flags;
  logic [DW-1:0]         out_depth;
  logic                  out_empty;
  logic                  out_full;
  logic                  out_overflow;
  logic                  out_underflow;

  // Control unit side: issues strobes and push data, samples the top entry.
  modport master (
    output in_push_en, in_pop_en, in_pc, in_flags,
    input  out_pc, out_flags, out_depth, out_empty, out_full,
           out_overflow, out_underflow
  );

  // Stack side: responds to strobes.
  modport slave (
    input  in_push_en, in_pop_en, in_pc, in_flags,
    output out_pc, out_flags, out_depth, out_empty, out_full,
           out_overflow, out_underflow
  );
endinterface

// File: rtl/call_stack_unit.sv
// Return-address/flags stack. Entries are {flags, pc}; sp points at the next
// free slot. The top entry is read combinationally so the control unit and PC
// can sample it on the same edge that retires the pop.
module call_stack_unit #(
  parameter int DEPTH      = 8,
  parameter int PC_WIDTH   = 8,
  parameter int FLAG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  call_stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int EW = FLAG_WIDTH + PC_WIDTH;

  logic [DW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          empty, full, wr_en;
  logic [AW-1:0] wr_idx, top_idx;
  logic [EW-1:0] top;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == DW'(DEPTH));
  assign top_idx = AW'(sp_q - DW'(1));

  // Next-state decode. A simultaneous push+pop on a non-empty stack replaces
  // the top in place, so it can neither overflow nor underflow; on an empty
  // stack it degrades to a plain push.
  always_comb begin
    sp_d   = sp_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    wr_en  = 1'b0;
    wr_idx = AW'(sp_q);
    if (bus.in_push_en && bus.in_pop_en && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (bus.in_push_en) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + DW'(1);
      end
    end else if (bus.in_pop_en) begin
      if (empty) udf_d = 1'b1;
      else       sp_d  = sp_q - DW'(1);
    end
  end

  // Stack pointer and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Entry storage is not reset; writes are blocked while rst is held.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= {bus.in_flags, bus.in_pc};
  end

  assign top               = empty ? '0 : mem_q[top_idx];
  assign bus.out_pc        = top[PC_WIDTH-1:0];
  assign bus.out_flags     = top[EW-1:PC_WIDTH];
  assign bus.out_depth     = sp_q;
  assign bus.out_empty     = empty;
  assign bus.out_full      = full;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = udf_q;
endmodule

// File: tb/tb_call_stack_unit.sv
// Directed bench for call_stack_unit with hand-computed expectations.
module tb_call_stack_unit;
  localparam int DEPTH = 8;
  localparam int PW    = 8;
  localparam int FW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  call_stack_unit_if #(.DEPTH(DEPTH), .PC_WIDTH(PW), .FLAG_WIDTH(FW)) bus ();

  call_stack_unit #(.DEPTH(DEPTH), .PC_WIDTH(PW), .FLAG_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_top(input string tag, input logic [7:0] pc, input logic [3:0] fl, input int depth);
    check({tag, ".pc"},    32'(bus.out_pc),    32'(pc));
    check({tag, ".flags"}, 32'(bus.out_flags), 32'(fl));
    check({tag, ".depth"}, 32'(bus.out_depth), 32'(depth));
  endtask

  // Drive strobes/data away from the rising edge, let the read path settle.
  task automatic drive(input logic push, input logic pop, input logic [7:0] pc, input logic [3:0] fl);
    @(negedge clk);
    bus.in_push_en = push;
    bus.in_pop_en  = pop;
    bus.in_pc      = pc;
    bus.in_flags   = fl;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    bus.in_push_en = 1'b0;
    bus.in_pop_en  = 1'b0;
  endtask

  task automatic push(input logic [7:0] pc, input logic [3:0] fl);
    drive(1'b1, 1'b0, pc, fl);
    clock();
  endtask

  task automatic pop();
    drive(1'b0, 1'b1, 8'h00, 4'h0);
    clock();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_push_en = 1'b0;
    bus.in_pop_en  = 1'b0;
    bus.in_pc      = '0;
    bus.in_flags   = '0;

    // Push held during reset must not take effect.
    bus.in_push_en = 1'b1;
    bus.in_pc      = 8'hAA;
    bus.in_flags   = 4'hA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.in_push_en = 1'b0;
    rst = 1'b0;
    #1;
    check_top("rst", 8'h00, 4'h0, 0);
    check("rst.empty", 32'(bus.out_empty), 1);
    check("rst.full",  32'(bus.out_full), 0);
    check("rst.ovf",   32'(bus.out_overflow), 0);
    check("rst.udf",   32'(bus.out_underflow), 0);

    // Basic push/push/pop ordering and zero-latency read.
    push(8'h12, 4'h1);
    push(8'h34, 4'h8);
    check_top("pp", 8'h34, 4'h8, 2);
    drive(1'b0, 1'b1, 8'h00, 4'h0);
    check_top("pop_during", 8'h34, 4'h8, 2);
    clock();
    check_top("pop_after", 8'h12, 4'h1, 1);
    pop();
    check("pp.empty", 32'(bus.out_empty), 1);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 4'(i));
    check("fill.full", 32'(bus.out_full), 1);
    check_top("fill", 8'h17, 4'h7, 8);
    push(8'hFF, 4'hF);
    check_top("ovf", 8'h17, 4'h7, 8);
    check("ovf.flag", 32'(bus.out_overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'h00, 4'h0);
      check("drain.pc",    32'(bus.out_pc),    32'(8'h17 - i));
      check("drain.flags", 32'(bus.out_flags), 32'(7 - i));
      clock();
    end
    check("drain.empty", 32'(bus.out_empty), 1);
    check("drain.ovf",   32'(bus.out_overflow), 1);

    // Underflow, then normal push.
    pop();
    check_top("udf", 8'h00, 4'h0, 0);
    check("udf.flag", 32'(bus.out_underflow), 1);
    push(8'h05, 4'h2);
    check_top("udf_push", 8'h05, 4'h2, 1);
    check("udf.sticky", 32'(bus.out_underflow), 1);
    check("udf.ovf",    32'(bus.out_overflow), 1);

    // Mid-run async reset with depth 3 takes effect before any edge.
    push(8'h06, 4'h3);
    push(8'h07, 4'h4);
    check("mid.depth3", 32'(bus.out_depth), 3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_top("mid_rst", 8'h00, 4'h0, 0);
    check("mid_rst.empty", 32'(bus.out_empty), 1);
    check("mid_rst.ovf",   32'(bus.out_overflow), 0);
    check("mid_rst.udf",   32'(bus.out_underflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Replace top at depth 1.
    push(8'h20, 4'h4);
    drive(1'b1, 1'b1, 8'h21, 4'h3);
    check_top("rep_during", 8'h20, 4'h4, 1);
    clock();
    check_top("rep_after", 8'h21, 4'h3, 1);

    // Replace at full: no overflow.
    for (int i = 0; i < DEPTH - 1; i++) push(8'(8'h60 + i), 4'(i + 8));
    check("rep_full.full", 32'(bus.out_full), 1);
    drive(1'b1, 1'b1, 8'h99, 4'hA);
    check_top("repf_during", 8'h66, 4'hE, 8);
    clock();
    check_top("repf_after", 8'h99, 4'hA, 8);
    check("repf.ovf", 32'(bus.out_overflow), 0);
    drive(1'b0, 1'b1, 8'h00, 4'h0);
    clock();
    check_top("repf_below", 8'h65, 4'hD, 7);

    // Push+pop on empty behaves as a push.
    for (int i = 0; i < DEPTH - 1; i++) pop();
    check("repe.empty", 32'(bus.out_empty), 1);
    drive(1'b1, 1'b1, 8'h55, 4'h5);
    clock();
    check_top("repe_after", 8'h55, 4'h5, 1);
    check("repe.udf", 32'(bus.out_underflow), 0);
    pop();

    // Control-unit call/return pattern.
    push(8'h40, 4'h1);
    repeat (3) clock();
    check_top("cu_idle", 8'h40, 4'h1, 1);
    drive(1'b0, 1'b1, 8'h00, 4'h0);
    check("cu.flags_at_pop", 32'(bus.out_flags), 1);
    check("cu.pc_at_pop",    32'(bus.out_pc), 32'h40);
    clock();
    check("cu.empty", 32'(bus.out_empty), 1);
    check("cu.udf",   32'(bus.out_underflow), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
